mole_round_ctrl: RTL and testbench

- Game-round engine for the whack-a-mole design.
- Sits between the keyboard decoder and the top-level game flow FSM.
- Picks the active hole and runs the round countdown. Judges each key press as a hit or a miss and keeps score and miss count.
- Drives the two status flags the flow FSM uses to leave the play screen: time expired (`time_up`) and miss limit reached (`miss_out`).

---
 rtl/mole_round_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_mole_round_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_round_ctrl.sv
// -----------------------------------------------------------------------------
// mole_round_ctrl
//
// Game-round engine for the whack-a-mole design. It sits between the keyboard
// decoder and the top-level game flow FSM. It picks the active hole, runs the
// round countdown, judges key presses as hits or misses, and keeps the score
// and the miss count. Two status flags tell the flow FSM when to leave the
// play screen: time expired (time_up) and miss limit reached (miss_out).
//
// Optional feature macro: MOLE_SPEEDUP_EN
//   defined   : after every 4th hit the mole-up window shrinks by UP_CYCLES/8,
//               but never below UP_CYCLES/2. The window returns to UP_CYCLES
//               at round start.
//   undefined : the mole-up window is fixed at UP_CYCLES.
//
// Ports
//   clk       in  1  system clock
//   rst       in  1  synchronous reset, active-low (0 = reset)
//   start     in  1  one-cycle pulse that begins a round (ignored while busy)
//   key_a/w/d/x/s in 1 one-cycle key pulses from the keyboard decoder
//   active    out 3  hole currently up: A=100 W=010 D=110 X=001 S=101, 000=none
//   score     out 7  hits this round, saturating at 99
//   misses    out 2  misses this round
//   timer     out 5  seconds remaining
//   time_up   out 1  round ended by timer expiry
//   miss_out  out 1  round ended by the miss limit
//   busy      out 1  round in progress
// -----------------------------------------------------------------------------
module mole_round_ctrl #(
    parameter int unsigned TICK_CYCLES = 100_000_000,
    parameter int unsigned ROUND_SECS  = 30,
    parameter int unsigned UP_CYCLES   = 75_000_000,
    parameter int unsigned GAP_CYCLES  = 25_000_000,
    parameter int unsigned MISS_LIMIT  = 3,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       key_a,
    input  logic       key_w,
    input  logic       key_d,
    input  logic       key_x,
    input  logic       key_s,
    output logic [2:0] active,
    output logic [6:0] score,
    output logic [1:0] misses,
    output logic [4:0] timer,
    output logic       time_up,
    output logic       miss_out,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_UP    = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0]  HOLE_NONE  = 3'b000;
    localparam logic [2:0]  HOLE_A     = 3'b100;
    localparam logic [2:0]  HOLE_W     = 3'b010;
    localparam logic [2:0]  HOLE_D     = 3'b110;
    localparam logic [2:0]  HOLE_X     = 3'b001;
    localparam logic [2:0]  HOLE_S     = 3'b101;
    // Index value that never matches a real hole, so the first mole of a
    // round is placed wherever the LFSR points.
    localparam logic [2:0]  IDX_NONE   = 3'd7;
    localparam logic [31:0] TICK_LAST  = 32'(TICK_CYCLES - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
    localparam logic [4:0]  ROUND_INIT = 5'(ROUND_SECS);
    localparam logic [1:0]  MISS_LIM   = 2'(MISS_LIMIT);
    localparam logic [6:0]  SCORE_MAX  = 7'd99;

    // Fold a 3-bit LFSR slice (0..7) onto the five holes.
    function automatic logic [2:0] idx_mod5(input logic [2:0] v);
        return (v >= 3'd5) ? (v - 3'd5) : v;
    endfunction

    // Hole index in order A, W, D, X, S to output code.
    function automatic logic [2:0] hole_code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = HOLE_A;
            3'd1:    code = HOLE_W;
            3'd2:    code = HOLE_D;
            3'd3:    code = HOLE_X;
            3'd4:    code = HOLE_S;
            default: code = HOLE_NONE;
        endcase
        return code;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [2:0]  active_q, active_d;
    logic [6:0]  score_q, score_d;
    logic [1:0]  misses_q, misses_d;
    logic [4:0]  timer_q, timer_d;
    logic        time_up_q, time_up_d;
    logic        miss_out_q, miss_out_d;
    logic        busy_q, busy_d;
    logic [2:0]  prev_idx_q, prev_idx_d;
    logic [31:0] up_cnt_q, up_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [31:0] presc_q, presc_d;

    logic [2:0]  spawn_idx;
    logic        key_any;
    logic        key_match;
    logic        hit_now;
    logic        miss_now;
    logic        miss_last;
    logic        tick_now;
    logic        time_last;
    logic [31:0] up_win;

`ifdef MOLE_SPEEDUP_EN
    localparam logic [31:0] WIN_FULL  = 32'(UP_CYCLES);
    localparam logic [31:0] WIN_STEP  = 32'(UP_CYCLES / 8);
    localparam logic [31:0] WIN_FLOOR = 32'(UP_CYCLES / 2);

    logic [31:0] win_q, win_d;
    logic [1:0]  hit_cnt_q, hit_cnt_d;

    assign up_win = win_q;
`else
    assign up_win = 32'(UP_CYCLES);
`endif

    assign key_any   = key_a | key_w | key_d | key_x | key_s;
    // Several keys in one cycle still count as a hit if any of them matches.
    assign key_match = (key_a && (active_q == HOLE_A)) ||
                       (key_w && (active_q == HOLE_W)) ||
                       (key_d && (active_q == HOLE_D)) ||
                       (key_x && (active_q == HOLE_X)) ||
                       (key_s && (active_q == HOLE_S));

    always_comb begin
        // 8-bit Fibonacci LFSR, taps 8,6,5,4; free-running in every state.
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        state_d    = state_q;
        active_d   = active_q;
        score_d    = score_q;
        misses_d   = misses_q;
        timer_d    = timer_q;
        time_up_d  = time_up_q;
        miss_out_d = miss_out_q;
        busy_d     = busy_q;
        prev_idx_d = prev_idx_q;
        up_cnt_d   = up_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        presc_d    = presc_q;
        spawn_idx  = idx_mod5(lfsr_q[2:0]);
        hit_now    = 1'b0;
        miss_now   = 1'b0;
        miss_last  = 1'b0;
        tick_now   = 1'b0;
`ifdef MOLE_SPEEDUP_EN
        win_d      = win_q;
        hit_cnt_d  = hit_cnt_q;
`endif

        // Second prescaler runs only while a round is in progress.
        if (busy_q) begin
            if (presc_q == TICK_LAST) begin
                tick_now = 1'b1;
                presc_d  = '0;
                timer_d  = timer_q - 5'd1;
            end else begin
                presc_d  = presc_q + 32'd1;
            end
        end
        time_last = tick_now && (timer_q == 5'd1);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_SPAWN;
                    busy_d     = 1'b1;
                    score_d    = '0;
                    misses_d   = '0;
                    timer_d    = ROUND_INIT;
                    presc_d    = '0;
                    time_up_d  = 1'b0;
                    miss_out_d = 1'b0;
                    prev_idx_d = IDX_NONE;
`ifdef MOLE_SPEEDUP_EN
                    win_d      = WIN_FULL;
                    hit_cnt_d  = '0;
`endif
                end
            end

            S_SPAWN: begin
                // Never show the same hole twice in a row.
                if (spawn_idx == prev_idx_q) begin
                    spawn_idx = (spawn_idx == 3'd4) ? 3'd0 : (spawn_idx + 3'd1);
                end
                active_d   = hole_code(spawn_idx);
                prev_idx_d = spawn_idx;
                up_cnt_d   = up_win - 32'd1;
                state_d    = S_UP;
            end

            S_UP: begin
                if (key_any) begin
                    if (key_match) begin
                        hit_now = 1'b1;
                    end else begin
                        miss_now = 1'b1;
                    end
                end else if (up_cnt_q == '0) begin
                    miss_now = 1'b1;
                end else begin
                    up_cnt_d = up_cnt_q - 32'd1;
                end

                if (hit_now) begin
                    score_d = (score_q == SCORE_MAX) ? score_q : (score_q + 7'd1);
`ifdef MOLE_SPEEDUP_EN
                    hit_cnt_d = hit_cnt_q + 2'd1;
                    if (hit_cnt_q == 2'd3) begin
                        win_d = (win_q >= (WIN_FLOOR + WIN_STEP)) ? (win_q - WIN_STEP) : WIN_FLOOR;
                    end
`endif
                end
                if (miss_now) begin
                    misses_d  = misses_q + 2'd1;
                    miss_last = ((misses_q + 2'd1) == MISS_LIM);
                end
                if (hit_now || miss_now) begin
                    active_d  = HOLE_NONE;
                    gap_cnt_d = GAP_LAST;
                    state_d   = S_GAP;
                end
            end

            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_SPAWN;
                end else begin
                    gap_cnt_d = gap_cnt_q - 32'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Round end overrides whatever the play states chose; a hit or miss
        // judged on the same edge has already been applied above.
        if (time_last || miss_last) begin
            state_d  = S_DONE;
            active_d = HOLE_NONE;
            busy_d   = 1'b0;
            if (time_last) begin
                time_up_d = 1'b1;
            end
            if (miss_last) begin
                miss_out_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            active_q   <= HOLE_NONE;
            score_q    <= '0;
            misses_q   <= '0;
            timer_q    <= ROUND_INIT;
            time_up_q  <= 1'b0;
            miss_out_q <= 1'b0;
            busy_q     <= 1'b0;
            prev_idx_q <= IDX_NONE;
            up_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            presc_q    <= '0;
`ifdef MOLE_SPEEDUP_EN
            win_q      <= WIN_FULL;
            hit_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            active_q   <= active_d;
            score_q    <= score_d;
            misses_q   <= misses_d;
            timer_q    <= timer_d;
            time_up_q  <= time_up_d;
            miss_out_q <= miss_out_d;
            busy_q     <= busy_d;
            prev_idx_q <= prev_idx_d;
            up_cnt_q   <= up_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            presc_q    <= presc_d;
`ifdef MOLE_SPEEDUP_EN
            win_q      <= win_d;
            hit_cnt_q  <= hit_cnt_d;
`endif
        end
    end

    assign active   = active_q;
    assign score    = score_q;
    assign misses   = misses_q;
    assign timer    = timer_q;
    assign time_up  = time_up_q;
    assign miss_out = miss_out_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Testbench for mole_round_ctrl: randomized play against a behavioural model.
module tb_mole_round_ctrl;

    localparam int TICK      = 100;
    localparam int UPC       = 40;
    localparam int GAPC      = 10;
    localparam int SECS      = 3;
    localparam int MLIM      = 3;
    localparam int ROUND_CYC = TICK * SECS;
    localparam int PH_SPAWN  = 0;
    localparam int PH_UP     = 1;
    localparam int PH_GAP    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       key_a = 1'b0, key_w = 1'b0, key_d = 1'b0, key_x = 1'b0, key_s = 1'b0;
    logic [2:0] active;
    logic [6:0] score;
    logic [1:0] misses;
    logic [4:0] timer;
    logic       time_up, miss_out, busy;

    always #5 clk = ~clk;

    mole_round_ctrl #(
        .TICK_CYCLES(TICK),
        .ROUND_SECS (SECS),
        .UP_CYCLES  (UPC),
        .GAP_CYCLES (GAPC),
        .MISS_LIMIT (MLIM),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .key_a   (key_a),
        .key_w   (key_w),
        .key_d   (key_d),
        .key_x   (key_x),
        .key_s   (key_s),
        .active  (active),
        .score   (score),
        .misses  (misses),
        .timer   (timer),
        .time_up (time_up),
        .miss_out(miss_out),
        .busy    (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] m_lfsr;
    logic [2:0] m_active;
    int         m_score, m_misses, m_timer;
    bit         m_tu, m_mo, m_busy;
    int         m_phase, m_bcyc, m_up_el, m_gap_el, m_prev;

    function automatic logic [2:0] code_of(input int idx);
        case (idx)
            0: return 3'b100;
            1: return 3'b010;
            2: return 3'b110;
            3: return 3'b001;
            default: return 3'b101;
        endcase
    endfunction

    task automatic model_step();
        int  idx;
        bit  fin_t, fin_m, judged, hit, anyk, miss;
        if (!rst) begin
            m_lfsr = 8'hA5; m_active = 3'b000; m_score = 0; m_misses = 0;
            m_timer = SECS; m_tu = 0; m_mo = 0; m_busy = 0;
            m_phase = PH_SPAWN; m_bcyc = 0; m_prev = -1;
            return;
        end
        fin_t = 0; fin_m = 0;
        if (m_busy) begin
            m_bcyc++;
            if (m_bcyc % TICK == 0) begin
                m_timer--;
                if (m_timer == 0) fin_t = 1;
            end
            case (m_phase)
                PH_SPAWN: begin
                    idx = int'(m_lfsr[2:0]) % 5;
                    if (idx == m_prev) idx = (idx + 1) % 5;
                    m_prev   = idx;
                    m_active = code_of(idx);
                    m_up_el  = 0;
                    m_phase  = PH_UP;
                end
                PH_UP: begin
                    judged = 0; miss = 0;
                    anyk = key_a | key_w | key_d | key_x | key_s;
                    hit  = (key_a && m_active == 3'b100) || (key_w && m_active == 3'b010) ||
                           (key_d && m_active == 3'b110) || (key_x && m_active == 3'b001) ||
                           (key_s && m_active == 3'b101);
                    if (anyk) begin
                        judged = 1;
                        if (hit) m_score = (m_score >= 99) ? 99 : m_score + 1;
                        else miss = 1;
                    end else begin
                        m_up_el++;
                        if (m_up_el == UPC) begin judged = 1; miss = 1; end
                    end
                    if (miss) begin
                        m_misses++;
                        if (m_misses == MLIM) fin_m = 1;
                    end
                    if (judged) begin m_active = 3'b000; m_phase = PH_GAP; m_gap_el = 0; end
                end
                default: begin
                    m_gap_el++;
                    if (m_gap_el == GAPC) m_phase = PH_SPAWN;
                end
            endcase
            if (fin_t || fin_m) begin
                m_busy = 0; m_active = 3'b000;
                if (fin_t) m_tu = 1;
                if (fin_m) m_mo = 1;
            end
        end else if (start) begin
            m_busy = 1; m_score = 0; m_misses = 0; m_timer = SECS;
            m_tu = 0; m_mo = 0; m_bcyc = 0; m_prev = -1; m_phase = PH_SPAWN;
        end
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    task automatic check_outputs();
        chk("active",   32'(active),   32'(m_active));
        chk("score",    32'(score),    32'(m_score));
        chk("misses",   32'(misses),   32'(m_misses));
        chk("timer",    32'(timer),    32'(m_timer));
        chk("time_up",  32'(time_up),  32'(m_tu));
        chk("miss_out", 32'(miss_out), 32'(m_mo));
        chk("busy",     32'(busy),     32'(m_busy));
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clear_inputs();
        start = 0; key_a = 0; key_w = 0; key_d = 0; key_x = 0; key_s = 0;
    endtask

    task automatic press_code(input logic [2:0] c);
        case (c)
            3'b100:  key_a = 1;
            3'b010:  key_w = 1;
            3'b110:  key_d = 1;
            3'b001:  key_x = 1;
            default: key_s = 1;
        endcase
    endtask

    task automatic press_wrong(input logic [2:0] c);
        if (c != 3'b100) key_a = 1;
        else key_w = 1;
    endtask

    task automatic pulse_start();
        start = 1;
        tick_cycle();
        start = 0;
    endtask

    task automatic wait_up(input string tag, input int max_cyc);
        int n = 0;
        while (!(m_busy && m_phase == PH_UP) && n < max_cyc) begin
            tick_cycle();
            n++;
        end
        if (!(m_busy && m_phase == PH_UP)) chk(tag, 0, 1);
    endtask

    bit final_hit;

    // policy 0: hit every mole; 1: never press; 2: random keys and stray starts
    task automatic run_play(input int policy, input bit align, input int max_cyc);
        int n = 0;
        int delay = $urandom_range(0, 8);
        int d, e;
        logic [4:0] mask;
        while (m_busy && n < max_cyc) begin
            clear_inputs();
            if (m_phase == PH_UP) begin
                d = ROUND_CYC - (m_bcyc + 1);
                e = m_up_el;
                if (policy == 0) begin
                    if (align && d <= UPC - (e + 1)) begin
                        if (d == 0) begin press_code(m_active); final_hit = 1; end
                    end else if (e >= delay && (!align || d > 12)) begin
                        press_code(m_active);
                        delay = $urandom_range(0, 8);
                    end
                end else if (policy == 2 && $urandom_range(0, 5) == 0) begin
                    mask = 5'($urandom_range(1, 31));
                    {key_a, key_w, key_d, key_x, key_s} = mask;
                end
            end
            if (policy == 2 && $urandom_range(0, 40) == 0) start = 1;
            tick_cycle();
            n++;
        end
        clear_inputs();
        if (m_busy) chk("play_timeout", 0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [2:0] h0, h1;
    int         sc;

    initial begin
        clear_inputs();
        rst = 0;
        repeat (2) tick_cycle();
        chk("rst_active", 32'(active), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_misses", 32'(misses), 0);
        chk("rst_timer", 32'(timer), SECS);
        chk("rst_time_up", 32'(time_up), 0);
        chk("rst_miss_out", 32'(miss_out), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1;
        repeat (3) tick_cycle();

        // Round A: wrong key, then hit, then unanswered moles to the miss limit
        pulse_start();
        chk("start_busy", 32'(busy), 1);
        wait_up("wait_up_a0", 20);
        h0 = active;
        press_wrong(m_active);
        tick_cycle();
        clear_inputs();
        chk("wrong_misses", 32'(misses), 1);
        chk("wrong_score", 32'(score), 0);
        chk("wrong_active_clear", 32'(active), 0);
        wait_up("wait_up_a1", 30);
        h1 = active;
        chk("new_hole_differs", 32'(h1 != h0), 1);
        press_code(m_active);
        tick_cycle();
        clear_inputs();
        chk("hit_score", 32'(score), 1);
        chk("hit_active_clear", 32'(active), 0);
        run_play(1, 0, 1000);
        chk("ml_misses", 32'(misses), 3);
        chk("ml_miss_out", 32'(miss_out), 1);
        chk("ml_busy", 32'(busy), 0);
        chk("ml_time_up", 32'(time_up), 0);
        repeat (5) tick_cycle();

        // Round B: hit every mole until the timer expires
        pulse_start();
        chk("restart_miss_out", 32'(miss_out), 0);
        chk("restart_timer", 32'(timer), SECS);
        run_play(0, 0, 1000);
        chk("exp_timer", 32'(timer), 0);
        chk("exp_time_up", 32'(time_up), 1);
        sc = int'(score);
        repeat (5) tick_cycle();
        chk("exp_score_held", 32'(score), 32'(sc));

        // Round C: hit lands on the final tick edge
        final_hit = 0;
        pulse_start();
        run_play(0, 1, 1000);
        chk("final_hit_taken", 32'(final_hit), 1);
        chk("final_time_up", 32'(time_up), 1);
        chk("final_busy", 32'(busy), 0);
        repeat (3) tick_cycle();
        pulse_start();
        chk("clr_time_up", 32'(time_up), 0);
        chk("clr_miss_out", 32'(miss_out), 0);
        chk("clr_timer", 32'(timer), SECS);

        // Reset during UP
        wait_up("wait_up_rst", 30);
        rst = 0;
        tick_cycle();
        rst = 1;
        chk("midrst_active", 32'(active), 0);
        chk("midrst_score", 32'(score), 0);
        chk("midrst_misses", 32'(misses), 0);
        chk("midrst_timer", 32'(timer), SECS);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_flags", 32'({time_up, miss_out}), 0);
        tick_cycle();

        // Random rounds
        for (int r = 0; r < 16; r++) begin
            repeat ($urandom_range(0, 7)) tick_cycle();
            pulse_start();
            run_play($urandom_range(0, 2), 0, 2000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
